wb_data_bridge: RTL and testbench

- Bridges the core's simple data-memory port to a Wishbone B3 classic master interface. The core port is ram_ce/we/addr/sel/data as used by openmips.
- Converts single-cycle core accesses into multi-cycle bus cycles.
- Raises a pipeline stall request until the slave acknowledges.
- Holds read data while the pipeline is stalled for other reasons. Sits between the openmips data port and the system bus or data RAM.

---
 rtl/wb_data_bridge.sv | 182 ++++++++++++++++++
 tb/tb_wb_data_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_data_bridge.sv
// Bridges the openmips single-cycle data port to a Wishbone B3 classic master.
// Each core access becomes one bus cycle; the pipeline is stalled until ack, flush or timeout.
module wb_data_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        timeout_hit_s;
    logic        stallreq_s;
    logic [31:0] cpu_data_s;

    assign timeout_hit_s = TO_EN && (state_q == ST_BUSY) && (cnt_q == TO_LAST);

    // Next-state logic: launch, terminate (flush > ack > timeout) or hold the bus cycle
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        rd_buf_d  = rd_buf_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i || wb_ack_i || timeout_hit_s) begin
                    adr_d = 32'd0;
                    dat_d = 32'd0;
                    sel_d = 4'd0;
                    we_d  = 1'b0;
                    cyc_d = 1'b0;
                    if (flush_i) begin
                        rd_buf_d = 32'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        // A timeout completes like an ack that returned zero data
                        rd_buf_d  = (wb_ack_i && !we_q) ? wb_dat_i : 32'd0;
                        bus_err_d = ~wb_ack_i;
                        state_d   = stall_i ? ST_WAIT : ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    rd_buf_d = 32'd0;
                    state_d  = ST_IDLE;
                end else if (!stall_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                adr_d    = 32'd0;
                dat_d    = 32'd0;
                sel_d    = 4'd0;
                we_d     = 1'b0;
                cyc_d    = 1'b0;
                rd_buf_d = 32'd0;
                cnt_d    = 32'd0;
            end
        endcase
    end

    // State and bus registers; async reset drops the bus cycle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rd_buf_q  <= 32'd0;
            cnt_q     <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Core-facing stall request and read data, valid in the ack cycle itself
    always_comb begin
        stallreq_s = 1'b0;
        cpu_data_s = 32'd0;
        case (state_q)
            ST_IDLE: begin
                stallreq_s = cpu_ce_i & ~flush_i;
            end
            ST_BUSY: begin
                stallreq_s = ~wb_ack_i & ~flush_i & ~timeout_hit_s;
                if (wb_ack_i && !we_q) begin
                    cpu_data_s = wb_dat_i;
                end else begin
                    cpu_data_s = 32'd0;
                end
            end
            ST_WAIT: begin
                cpu_data_s = rd_buf_q;
            end
            default: begin
                stallreq_s = 1'b0;
                cpu_data_s = 32'd0;
            end
        endcase
    end

    // Gated by reset so the core sees no stall while the bridge is held in reset
    assign stallreq_o = stallreq_s & rst;
    assign cpu_data_o = rst ? cpu_data_s : 32'd0;
    assign bus_err_o  = bus_err_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;

endmodule

// File: tb/tb_wb_data_bridge.sv
// Self-checking bench for wb_data_bridge: directed scenarios plus random transactions
// checked against a transaction-level model of the bridge's observable behaviour.
module tb_wb_data_bridge;

    localparam int TO = 4;
    localparam int K_ACK = 0;
    localparam int K_TMO = 1;
    localparam int K_FLUSH = 2;

    logic        clk;
    logic        rst;
    logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        stallreq_o, bus_err_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    wb_data_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One core access. waits = cycles before the slave acks, s = cycles the
    // result is held for the stalled pipeline, f = BUSY cycle of a flush (-1 none).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int waits, input int s, input int f,
                           input logic [31:0] rdata);
        int nat_end, end_k, kind, s_eff;
        logic [31:0] held;
        nat_end = (waits < TO) ? waits : TO - 1;
        kind    = (waits < TO) ? K_ACK : K_TMO;
        end_k   = nat_end;
        if (f >= 0 && f <= nat_end) begin
            end_k = f;
            kind  = K_FLUSH;
        end
        held  = (kind == K_ACK && !we) ? rdata : 32'h0;
        s_eff = (kind == K_FLUSH) ? 0 : s;

        next_cycle();
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdat;
        cpu_sel_i = sel; flush_i = 1'b0; stall_i = 1'b0; wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        #2;
        checkb("req_stallreq", stallreq_o, 1'b1);
        checkb("req_cyc", wb_cyc_o, 1'b0);

        for (int k = 0; k <= end_k; k++) begin
            next_cycle();
            cpu_addr_i = $urandom; cpu_data_i = $urandom;
            cpu_sel_i = 4'($urandom); cpu_we_i = 1'($urandom);
            wb_ack_i = (k == waits);
            flush_i  = (kind == K_FLUSH && k == f);
            stall_i  = (k == end_k) ? (s_eff > 0) : 1'($urandom);
            wb_dat_i = (k == waits) ? rdata : $urandom;
            #2;
            checkb("busy_cyc", wb_cyc_o, 1'b1);
            checkb("busy_stb", wb_stb_o, 1'b1);
            check("busy_adr", wb_adr_o, addr);
            check("busy_dat", wb_dat_o, wdat);
            check("busy_sel", {28'h0, wb_sel_o}, {28'h0, sel});
            checkb("busy_we", wb_we_o, we);
            checkb("busy_stallreq", stallreq_o, k != end_k);
            check("busy_cpu_data", cpu_data_o, (k == waits && !we) ? rdata : 32'h0);
            checkb("busy_bus_err", bus_err_o, 1'b0);
        end

        for (int a = 1; a <= s_eff + 2; a++) begin
            next_cycle();
            cpu_ce_i = 1'b0; flush_i = 1'b0;
            wb_ack_i = (kind == K_FLUSH && a == 1);
            wb_dat_i = $urandom;
            stall_i  = (a < s_eff);
            #2;
            checkb("post_cyc", wb_cyc_o, 1'b0);
            checkb("post_stb", wb_stb_o, 1'b0);
            checkb("post_stallreq", stallreq_o, 1'b0);
            check("post_cpu_data", cpu_data_o, (a <= s_eff) ? held : 32'h0);
            checkb("post_bus_err", bus_err_o, (a == 1 && kind == K_TMO));
            if (a == 1) begin
                check("post_adr", wb_adr_o, 32'h0);
                check("post_dat", wb_dat_o, 32'h0);
                check("post_sel", {28'h0, wb_sel_o}, 32'h0);
                checkb("post_we", wb_we_o, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = 32'h0; cpu_sel_i = 4'h0; cpu_data_i = 32'h0;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0;
        repeat (2) next_cycle();
        #2;
        checkb("rst_cyc", wb_cyc_o, 1'b0);
        checkb("rst_stb", wb_stb_o, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        checkb("rst_stallreq", stallreq_o, 1'b0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        checkb("rst_bus_err", bus_err_o, 1'b0);
        next_cycle();
        rst = 1'b1;

        // zero-wait read, 3-wait write, read held over a 2-cycle stall
        run_txn(1'b0, 32'h0000_0010, 32'h0BAD_0BAD, 4'hF, 0, 0, -1, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3, 0, -1, 32'hFFFF_FFFF);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 1, 2, -1, 32'hA5A5_A5A5);
        // flush in the 2nd BUSY cycle, ack arriving late
        run_txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 2, 0, 1, 32'h1111_2222);
        // slave never acks: timeout, then timeout while the pipeline is stalled
        run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 20, 0, -1, 32'h3333_4444);
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'hC, 20, 1, -1, 32'h5555_6666);

        // reset while BUSY drops the cycle without a clock edge
        next_cycle();
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'hF;
        wb_ack_i = 1'b0;
        #2;
        next_cycle();
        #2;
        checkb("pre_rst_cyc", wb_cyc_o, 1'b1);
        #1 rst = 1'b0;
        #1;
        checkb("async_rst_cyc", wb_cyc_o, 1'b0);
        checkb("async_rst_stb", wb_stb_o, 1'b0);
        checkb("async_rst_stallreq", stallreq_o, 1'b0);
        next_cycle();
        rst = 1'b1; cpu_ce_i = 1'b0;
        #2;
        checkb("rst_release_cyc", wb_cyc_o, 1'b0);
        run_txn(1'b0, 32'h0000_0304, 32'h0, 4'hF, 1, 0, -1, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                    $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
